// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: 4-entry byte FIFO, EN strobe timing.
// Define LCD_AUTO_INIT_EN to add the power-up wait and init command sequence.
module lcd_ctrl #(
  parameter int T_POWERUP   = 1000000,
  parameter int T_SETUP     = 3,
  parameter int T_PULSE     = 25,
  parameter int T_HOLD      = 3,
  parameter int T_EXEC      = 2500,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic       i_wr_rs,
  input  logic [7:0] i_wr_data,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_busy,
  output logic [2:0] o_fifo_count
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP),
                                   max2(T_PULSE, T_HOLD)),
                              max2(T_EXEC, T_EXEC_LONG));
  localparam int CW = $clog2(T_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [2:0] {
    INIT_WAIT,
    INIT_SEQ,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

`ifdef LCD_AUTO_INIT_EN
  localparam state_t RST_STATE = INIT_WAIT;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       run_q;

  logic [8:0] mem [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] count_q;
  logic       push, pop;
  logic       long_exec;
  cnt_t       exec_ld;

`ifdef LCD_AUTO_INIT_EN
  logic [2:0] idx_q, idx_d;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction
`endif

  // Full FIFO never bypasses, even on a same-cycle pop
  assign o_wr_ready   = run_q && (count_q < 3'd4);
  assign push         = i_wr_valid && o_wr_ready;
  assign o_fifo_count = count_q;
  assign o_lcd_data   = data_q;
  assign o_lcd_rs     = rs_q;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = (state_q == PULSE);
  assign o_lcd_on     = run_q;
  assign o_busy       = (state_q != IDLE) || (count_q != 3'd0);

  // Clear and home commands need the long execution wait
  assign long_exec = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) ||
                               (data_q == 8'h03));
  assign exec_ld   = long_exec ? cnt_t'(T_EXEC_LONG - 1) : cnt_t'(T_EXEC - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef LCD_AUTO_INIT_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
`ifdef LCD_AUTO_INIT_EN
      INIT_WAIT: begin
        if (cnt_q == cnt_t'(T_POWERUP - 1)) begin
          state_d = INIT_SEQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      INIT_SEQ: begin
        rs_d    = 1'b0;
        data_d  = init_cmd(idx_q);
        idx_d   = idx_q + 3'd1;
        state_d = SETUP;
        cnt_d   = cnt_t'(T_SETUP - 1);
      end
`endif
      IDLE: begin
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          rs_d    = mem[rptr_q][8];
          data_d  = mem[rptr_q][7:0];
          state_d = SETUP;
          cnt_d   = cnt_t'(T_SETUP - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = cnt_t'(T_PULSE - 1);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = cnt_t'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = EXEC;
          cnt_d   = exec_ld;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
`ifdef LCD_AUTO_INIT_EN
          state_d = (idx_q < 3'd4) ? INIT_SEQ : IDLE;
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      run_q   <= 1'b0;
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
`ifdef LCD_AUTO_INIT_EN
      idx_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      run_q   <= 1'b1;
      if (push) wptr_q <= wptr_q + 2'd1;
      if (pop)  rptr_q <= rptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
`ifdef LCD_AUTO_INIT_EN
      idx_q   <= idx_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q] <= {i_wr_rs, i_wr_data};
  end

endmodule
